decimal_entry: RTL

//   Inverse of the binary-to-decimal display path. Accepts decimal digits one at a time,

---
 rtl/decimal_entry.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/decimal_entry.sv
// Builds a binary value from MSD-first BCD digits (3 edges per digit), committed on enter; saturates at 2**WIDTH-1.
// No backpressure: strobes that arrive while busy are dropped and flagged. Optional echo display under `ECHO_DISPLAY_EN.
module decimal_entry #(
    parameter int WIDTH      = 6,
    parameter int MAX_DIGITS = 2
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic [3:0]       digit_in,
    input  logic             digit_valid,
    input  logic             enter,
    input  logic             clear,
    output logic [WIDTH-1:0] value_out,
    output logic             value_valid,
    output logic             busy,
    output logic [1:0]       digit_count,
    output logic             error
`ifdef ECHO_DISPLAY_EN
    ,
    output logic [6:0]       hex0,
    output logic [6:0]       hex1
`endif
);

    localparam int ACC_W = WIDTH + 4;
    localparam logic [ACC_W-1:0] MAX_VAL = ACC_W'((1 << WIDTH) - 1);
    localparam logic [1:0]       MAX_CNT = 2'(MAX_DIGITS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCUM,
        S_MUL1,
        S_MUL2
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [ACC_W-1:0]   r_acc;
    logic [ACC_W-1:0]   r_tmp;
    logic [3:0]         r_dreg;
    logic [1:0]         r_cnt;
    logic               r_err;
    logic [WIDTH-1:0]   r_value;
    logic               r_value_vld;
    logic               w_accept;
    logic               w_commit;
    logic               w_err_set;
    logic [WIDTH-1:0]   w_sat;

    assign w_sat = (r_acc > MAX_VAL) ? MAX_VAL[WIDTH-1:0] : r_acc[WIDTH-1:0];

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Priority clear > enter > digit_valid; digit+enter together is always a rejected digit.
    always_comb begin
        w_next    = r_state;
        w_accept  = 1'b0;
        w_commit  = 1'b0;
        w_err_set = 1'b0;
        busy      = (r_state == S_MUL1) || (r_state == S_MUL2);
        if (clear) begin
            w_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE, S_ACCUM: begin
                    if (enter) begin
                        if (r_state == S_ACCUM) begin
                            w_commit = 1'b1;
                            w_next   = S_IDLE;
                            if (r_acc > MAX_VAL) begin
                                w_err_set = 1'b1;
                            end
                        end
                        if (digit_valid) begin
                            w_err_set = 1'b1;
                        end
                    end else if (digit_valid) begin
                        if ((digit_in <= 4'd9) && (r_cnt < MAX_CNT)) begin
                            w_accept = 1'b1;
                            w_next   = S_MUL1;
                        end else begin
                            w_err_set = 1'b1;
                        end
                    end
                end
                S_MUL1: begin
                    w_next    = S_MUL2;
                    w_err_set = enter || digit_valid;
                end
                default: begin
                    w_next    = S_ACCUM;
                    w_err_set = enter || digit_valid;
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_acc       <= '0;
            r_tmp       <= '0;
            r_dreg      <= '0;
            r_cnt       <= '0;
            r_err       <= 1'b0;
            r_value     <= '0;
            r_value_vld <= 1'b0;
        end else if (clear) begin
            r_acc       <= '0;
            r_cnt       <= '0;
            r_err       <= 1'b0;
            r_value_vld <= 1'b0;
        end else begin
            r_value_vld <= w_commit;
            if (w_err_set) begin
                r_err <= 1'b1;
            end
            if (w_commit) begin
                r_value <= w_sat;
                r_acc   <= '0;
                r_cnt   <= '0;
            end
            if (w_accept) begin
                r_dreg <= digit_in;
            end
            // acc*10 + digit split as (acc<<3) then + (acc<<1) + digit.
            if (r_state == S_MUL1) begin
                r_tmp <= r_acc << 3;
            end
            if (r_state == S_MUL2) begin
                r_acc <= r_tmp + (r_acc << 1) + ACC_W'(r_dreg);
                r_cnt <= r_cnt + 2'd1;
            end
        end
    end

    assign value_out   = r_value;
    assign value_valid = r_value_vld;
    assign digit_count = r_cnt;
    assign error       = r_err;

`ifdef ECHO_DISPLAY_EN
    logic [3:0] r_echo0;
    logic [3:0] r_echo1;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_echo0 <= '0;
            r_echo1 <= '0;
        end else if (clear || w_commit) begin
            r_echo0 <= '0;
            r_echo1 <= '0;
        end else if (w_accept) begin
            r_echo0 <= digit_in;
            r_echo1 <= r_echo0;
        end
    end

    HexDecoder u_hex0 (.i_digit(r_echo0), .o_seg(hex0));
    HexDecoder u_hex1 (.i_digit(r_echo1), .o_seg(hex1));
`endif

endmodule

`ifdef ECHO_DISPLAY_EN
// Seven-segment decoder, segments {g,f,e,d,c,b,a}, active-low.
module HexDecoder (
    input  logic [3:0] i_digit,
    output logic [6:0] o_seg
);
    always_comb begin
        o_seg = 7'h7F;
        case (i_digit)
            4'h0: o_seg = 7'b1000000;
            4'h1: o_seg = 7'b1111001;
            4'h2: o_seg = 7'b0100100;
            4'h3: o_seg = 7'b0110000;
            4'h4: o_seg = 7'b0011001;
            4'h5: o_seg = 7'b0010010;
            4'h6: o_seg = 7'b0000010;
            4'h7: o_seg = 7'b1111000;
            4'h8: o_seg = 7'b0000000;
            4'h9: o_seg = 7'b0010000;
            4'hA: o_seg = 7'b0001000;
            4'hB: o_seg = 7'b0000011;
            4'hC: o_seg = 7'b1000110;
            4'hD: o_seg = 7'b0100001;
            4'hE: o_seg = 7'b0000110;
            default: o_seg = 7'b0001110;
        endcase
    end
endmodule
`endif
